// File: rtl/playlist_ctrl.sv
// playlist_ctrl: transport/track/beat sequencer above the tone datapath (optional shuffle via SHUFFLE_EN)
module playlist_ctrl #(
    parameter int NUM_TRACKS  = 4,
    parameter int TRACK_W     = 2,
    parameter int BEAT_W      = 8,
    parameter int RESTART_THR = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_beat_tick,
    input  logic               i_play_pause,
    input  logic               i_next_trk,
    input  logic               i_prev_trk,
    input  logic [1:0]         i_loop_mode,
    input  logic [BEAT_W-1:0]  i_track_len,
`ifdef SHUFFLE_EN
    input  logic               i_shuffle,
`endif
    output logic [TRACK_W-1:0] o_track,
    output logic [BEAT_W-1:0]  o_ibeat,
    output logic               o_in_pause,
    output logic               o_track_start
);
    typedef enum logic [1:0] {ST_STOP, ST_PLAY, ST_PAUSE} state_t;
    localparam logic [TRACK_W-1:0] LAST = TRACK_W'(NUM_TRACKS - 1);
    state_t              r_state, w_state_n;
    logic [TRACK_W-1:0]  r_track, w_track_n, w_inc, w_dec, w_adv;
    logic [BEAT_W-1:0]   r_ibeat, w_ibeat_n, w_len_m1;
    logic                r_in_pause, r_track_start;
    logic                w_next, w_prev, w_tick, w_eot, w_seq_done, w_restart;
    assign w_next   = i_next_trk & ~i_prev_trk;
    assign w_prev   = i_prev_trk & ~i_next_trk;
    assign w_tick   = i_beat_tick & (r_state == ST_PLAY) & ~i_play_pause & ~i_next_trk & ~i_prev_trk;
    assign w_len_m1 = (i_track_len == '0) ? '0 : i_track_len - BEAT_W'(1);
    assign w_eot    = w_tick & (r_ibeat >= w_len_m1);
    assign w_inc    = (r_track == LAST) ? '0 : r_track + TRACK_W'(1);
    assign w_dec    = (r_track == '0) ? LAST : r_track - TRACK_W'(1);
`ifdef SHUFFLE_EN
    logic [7:0]         r_lfsr, r_seq_cnt;
    logic [TRACK_W-1:0] w_cand;
    assign w_cand     = TRACK_W'(r_lfsr % 8'(NUM_TRACKS));
    assign w_adv      = !i_shuffle ? w_inc : (w_cand == r_track) ? ((w_cand == LAST) ? '0 : w_cand + TRACK_W'(1)) : w_cand;
    assign w_seq_done = i_shuffle ? (r_seq_cnt == 8'(NUM_TRACKS - 1)) : (r_track == LAST);
    // Free-running LFSR for shuffle picks and count of sequence advances since last stop
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_lfsr    <= 8'hA5;
            r_seq_cnt <= '0;
        end else begin
            r_lfsr    <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
            r_seq_cnt <= (w_state_n == ST_STOP) ? '0 : (w_eot && i_loop_mode == 2'd3) ? r_seq_cnt + 8'd1 : r_seq_cnt;
        end
    end
`else
    assign w_adv      = w_inc;
    assign w_seq_done = (r_track == LAST);
`endif
    // Next-state: buttons beat ticks, then the transport toggle acts on the post-button position
    always_comb begin
        w_state_n = r_state;
        w_track_n = r_track;
        w_ibeat_n = r_ibeat;
        w_restart = 1'b0;
        if (w_next) begin
            w_track_n = w_adv;
            w_ibeat_n = '0;
            w_restart = 1'b1;
        end else if (w_prev) begin
            w_track_n = (r_ibeat >= BEAT_W'(RESTART_THR)) ? r_track : w_dec;
            w_ibeat_n = '0;
            w_restart = 1'b1;
        end else if (w_tick && !w_eot) begin
            w_ibeat_n = r_ibeat + BEAT_W'(1);
        end else if (w_eot) begin
            w_ibeat_n = '0;
            w_restart = 1'b1;
            case (i_loop_mode)
                2'd0:    w_state_n = ST_STOP;
                2'd1:    w_track_n = r_track;
                2'd2:    w_track_n = w_adv;
                default: begin
                    w_state_n = w_seq_done ? ST_STOP : ST_PLAY;
                    w_track_n = w_seq_done ? '0 : w_adv;
                end
            endcase
        end
        if (i_play_pause) begin
            case (r_state)
                ST_STOP: begin
                    w_state_n = ST_PLAY;
                    w_ibeat_n = '0;
                    w_restart = 1'b1;
                end
                ST_PLAY: w_state_n = ST_PAUSE;
                default: w_state_n = ST_PLAY;
            endcase
        end
    end
    // Transport state and registered outputs, all taken from the next-state values
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_STOP;
            r_track       <= '0;
            r_ibeat       <= '0;
            r_in_pause    <= 1'b1;
            r_track_start <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_track       <= w_track_n;
            r_ibeat       <= w_ibeat_n;
            r_in_pause    <= (w_state_n != ST_PLAY);
            r_track_start <= w_restart && (w_state_n == ST_PLAY);
        end
    end
    assign o_track       = r_track;
    assign o_ibeat       = r_ibeat;
    assign o_in_pause    = r_in_pause;
    assign o_track_start = r_track_start;
endmodule

// File: tb/tb_playlist_ctrl.sv
// tb_playlist_ctrl: directed self-checking bench for playlist_ctrl (default build)
module tb_playlist_ctrl;
    logic       clk = 0, rst = 0, tick = 0, pp = 0, nx = 0, pv = 0;
    logic [1:0] mode = 2'd0;
    logic [7:0] len = 8'd4;
    logic [1:0] trk;
    logic [7:0] ib;
    logic       inp, ts;
    int         n_total = 0, n_pass = 0;

    always #5 clk = ~clk;

    playlist_ctrl dut (
        .i_clk(clk), .i_reset(rst), .i_beat_tick(tick), .i_play_pause(pp),
        .i_next_trk(nx), .i_prev_trk(pv), .i_loop_mode(mode), .i_track_len(len),
        .o_track(trk), .o_ibeat(ib), .o_in_pause(inp), .o_track_start(ts)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic p, input logic n, input logic v, input logic t);
        pp = p; nx = n; pv = v; tick = t;
        cyc();
        pp = 0; nx = 0; pv = 0; tick = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1);
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic all(input string tag, input logic [1:0] t, input logic [7:0] b, input logic p, input logic s);
        chk({tag, ".track"}, {6'd0, trk}, {6'd0, t});
        chk({tag, ".ibeat"}, ib, b);
        chk({tag, ".in_pause"}, {7'd0, inp}, {7'd0, p});
        chk({tag, ".track_start"}, {7'd0, ts}, {7'd0, s});
    endtask

    initial begin
        #2 rst = 1;
        cyc(); cyc();
        all("reset", 2'd0, 8'd0, 1, 0);
        rst = 0;
        cyc();
        all("idle", 2'd0, 8'd0, 1, 0);
        // ONCE playback of a 4-beat track
        step(1, 0, 0, 0);   all("t1.start", 2'd0, 8'd0, 0, 1);
        ticks(1);           all("t1.b1", 2'd0, 8'd1, 0, 0);
        ticks(1);           all("t1.b2", 2'd0, 8'd2, 0, 0);
        ticks(1);           all("t1.b3", 2'd0, 8'd3, 0, 0);
        ticks(1);           all("t1.end", 2'd0, 8'd0, 1, 0);
        ticks(1);           all("t1.stopped", 2'd0, 8'd0, 1, 0);
        // REPEAT_ALL wrap from last track, then track_len==0 treated as 1
        step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
        all("t2.sel3", 2'd3, 8'd0, 1, 0);
        mode = 2'd2; len = 8'd1;
        step(1, 0, 0, 0);   all("t2.play", 2'd3, 8'd0, 0, 1);
        ticks(1);           all("t2.wrap", 2'd0, 8'd0, 0, 1);
        len = 8'd0;
        ticks(1);           all("t2.len0", 2'd1, 8'd0, 0, 1);
        // pause holds ibeat and ignores ticks; resume without track_start
        mode = 2'd1; len = 8'd20;
        ticks(5);           all("t3.b5", 2'd1, 8'd5, 0, 0);
        step(1, 0, 0, 0);   all("t3.pause", 2'd1, 8'd5, 1, 0);
        ticks(3);           all("t3.held", 2'd1, 8'd5, 1, 0);
        step(1, 0, 0, 0);   all("t3.resume", 2'd1, 8'd5, 0, 0);
        ticks(1);           all("t3.b6", 2'd1, 8'd6, 0, 0);
        // prev restarts at/above threshold, otherwise steps back with wrap
        ticks(4);           all("t4.b10", 2'd1, 8'd10, 0, 0);
        step(0, 0, 1, 0);   all("t4.restart", 2'd1, 8'd0, 0, 1);
        ticks(2);
        step(0, 0, 1, 0);   all("t4.back", 2'd0, 8'd0, 0, 1);
        ticks(2);
        step(0, 0, 1, 0);   all("t4.wrap", 2'd3, 8'd0, 0, 1);
        ticks(8);
        step(0, 0, 1, 0);   all("t4.thr8", 2'd3, 8'd0, 0, 1);
        ticks(7);
        step(0, 0, 1, 0);   all("t4.thr7", 2'd2, 8'd0, 0, 1);
        // simultaneous events
        ticks(3);
        step(0, 1, 1, 0);   all("t5.both", 2'd2, 8'd3, 0, 0);
        step(0, 1, 0, 1);   all("t5.next_tick", 2'd3, 8'd0, 0, 1);
        mode = 2'd0; len = 8'd1;
        step(1, 0, 0, 1);   all("t5.pp_eot", 2'd3, 8'd0, 1, 0);
        step(1, 0, 0, 0);   all("t5.resume", 2'd3, 8'd0, 0, 0);
        // SEQUENCE advances, then stops after the last track
        mode = 2'd3;
        step(0, 1, 0, 0);   all("t7.next_wrap", 2'd0, 8'd0, 0, 1);
        step(0, 1, 0, 0); step(0, 1, 0, 0);
        ticks(1);           all("t7.adv", 2'd3, 8'd0, 0, 1);
        ticks(1);           all("t7.stop", 2'd0, 8'd0, 1, 0);
        step(1, 1, 0, 0);   all("t7.pp_next", 2'd1, 8'd0, 0, 1);
        // asynchronous reset mid-play
        step(0, 1, 0, 0);
        mode = 2'd1; len = 8'd20;
        ticks(7);           all("t6.pre", 2'd2, 8'd7, 0, 0);
        @(negedge clk);
        rst = 1;
        #1;                 all("t6.async", 2'd0, 8'd0, 1, 0);
        cyc();
        rst = 0;
        cyc();              all("t6.after", 2'd0, 8'd0, 1, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
